jk_register_bank: RTL and testbench

JK_REGISTER_BANK -- requirements
Module: jk_register_bank

---
 rtl/jk_register_bank.sv | 93 +++++++++
 tb/tb_jk_register_bank.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/jk_register_bank.sv
// jk_register_bank
// A bank of WIDTH JK-style bits with four operating modes, selected per cycle:
//   00 JK    : per-bit hold / clear / set / toggle from j and k
//   01 load  : parallel load from load_data
//   10 count : wrapping up-counter that returns to 0 after MAX_COUNT
//   11 shift : left shift, serial_in enters at bit 0
//
// Ports
//   clock      : rising-edge clock for all state
//   reset      : synchronous, active-high; clears q and changed
//   enable     : update qualifier; 0 holds q and forces changed low
//   mode       : operation select (see above)
//   j, k       : per-bit JK inputs (JK mode)
//   load_data  : parallel load value (load mode)
//   serial_in  : shift input (shift mode)
//   q, q_bar   : registered bank state and its complement
//   terminal   : high while counting and q equals MAX_COUNT
//   serial_out : current MSB of q
//   changed    : one-cycle pulse after an enabled edge that altered q
module jk_register_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             terminal,
  output logic             serial_out,
  output logic             changed
);

  localparam logic [1:0] MODE_JK    = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_COUNT = 2'b10;
  localparam logic [1:0] MODE_SHIFT = 2'b11;

  logic [WIDTH-1:0] q_next;

  // JK characteristic equation: a set bit survives unless k, a clear bit
  // rises when j; j=k=1 therefore toggles.
  function automatic logic [WIDTH-1:0] jk_apply(
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] jv,
    input logic [WIDTH-1:0] kv
  );
    return (cur & ~kv) | (~cur & jv);
  endfunction

  // A value above MAX_COUNT (reachable via load or JK) wraps straight to 0
  // rather than counting up through the illegal range.
  function automatic logic [WIDTH-1:0] count_apply(input logic [WIDTH-1:0] cur);
    if (cur >= MAX_COUNT) begin
      return '0;
    end
    return cur + WIDTH'(1);
  endfunction

  always_comb begin
    q_next = q;
    case (mode)
      MODE_JK:    q_next = jk_apply(q, j, k);
      MODE_LOAD:  q_next = load_data;
      MODE_COUNT: q_next = count_apply(q);
      MODE_SHIFT: q_next = {q[WIDTH-2:0], serial_in};
      default:    q_next = q;
    endcase
  end

  // Stage 0: bank state and change flag
  always_ff @(posedge clock) begin
    if (reset) begin
      q       <= '0;
      changed <= 1'b0;
    end else if (enable) begin
      q       <= q_next;
      changed <= (q_next != q);
    end else begin
      changed <= 1'b0;
    end
  end

  assign q_bar      = ~q;
  assign terminal   = (mode == MODE_COUNT) && (q == MAX_COUNT);
  assign serial_out = q[WIDTH-1];

endmodule

// File: tb/tb_jk_register_bank.sv
// Randomized plus directed bench for jk_register_bank (WIDTH=4, MAX_COUNT=9)
// against a behavioural model of the bank kept as an integer value.
module tb_jk_register_bank;

  localparam int WIDTH = 4;
  localparam int MAXC  = 9;

  logic             clock;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] load_data;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             terminal;
  logic             serial_out;
  logic             changed;

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  int m_q       = 0;
  int m_changed = 0;

  jk_register_bank #(.WIDTH(WIDTH), .MAX_COUNT(4'd9)) dut (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode),
    .j(j), .k(k), .load_data(load_data), .serial_in(serial_in),
    .q(q), .q_bar(q_bar), .terminal(terminal), .serial_out(serial_out),
    .changed(changed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // Model of one clock edge, written from the operating rules.
  task automatic model_edge(input bit r, input bit e, input int md,
                            input int jv, input int kv, input int ld, input bit si);
    int nq;
    if (r) begin
      m_q = 0; m_changed = 0;
      return;
    end
    if (!e) begin
      m_changed = 0;
      return;
    end
    nq = m_q;
    case (md)
      0: begin
        nq = 0;
        for (int i = 0; i < WIDTH; i++) begin
          int bq, bj, bk, bn;
          bq = (m_q >> i) & 1; bj = (jv >> i) & 1; bk = (kv >> i) & 1;
          if (!bj && !bk)      bn = bq;
          else if (!bj && bk)  bn = 0;
          else if (bj && !bk)  bn = 1;
          else                 bn = 1 - bq;
          nq += bn << i;
        end
      end
      1: nq = ld;
      2: nq = (m_q >= MAXC) ? 0 : m_q + 1;
      default: nq = (m_q * 2 + int'(si)) % (1 << WIDTH);
    endcase
    m_changed = (nq != m_q) ? 1 : 0;
    m_q = nq;
  endtask

  task automatic check_outputs(input int md);
    check("q",          32'(q),          32'(m_q));
    check("q_bar",      32'(q_bar),      32'((~m_q) & 15));
    check("changed",    32'(changed),    32'(m_changed));
    check("terminal",   32'(terminal),   32'((md == 2 && m_q == MAXC) ? 1 : 0));
    check("serial_out", 32'(serial_out), 32'((m_q >> (WIDTH - 1)) & 1));
  endtask

  // Drive one cycle of inputs, take the edge, then compare just after it.
  task automatic step(input bit r, input bit e, input int md,
                      input int jv, input int kv, input int ld, input bit si);
    reset = r; enable = e; mode = 2'(md);
    j = 4'(jv); k = 4'(kv); load_data = 4'(ld); serial_in = si;
    @(posedge clock);
    model_edge(r, e, md, jv, kv, ld, si);
    #1;
    check_outputs(md);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; mode = 2'b11; j = '1; k = '1;
    load_data = '1; serial_in = 1'b1;

    // Reset with all other inputs active
    step(1, 1, 1, 15, 15, 15, 1);
    step(1, 0, 2, 15, 0, 7, 1);

    // JK: mixed hold/clear/set/toggle, then all-toggle
    step(0, 1, 0, 4'b1010, 4'b0110, 0, 0);
    step(0, 1, 0, 4'b1111, 4'b1111, 0, 0);
    // JK hold and load of equal value produce no change pulse
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, m_q, 0);

    // Count 11 edges from 0 through the MAX_COUNT wrap
    step(1, 0, 2, 0, 0, 0, 0);
    for (int i = 0; i < 11; i++) step(0, 1, 2, 15, 15, 15, 1);

    // Load above MAX_COUNT, then count wraps directly to 0
    step(0, 1, 1, 0, 0, 4'b1110, 0);
    step(0, 1, 2, 0, 0, 0, 0);

    // Count, freeze for 3 edges, resume, reset mid-count
    step(0, 1, 2, 0, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 2, 15, 15, 15, 1);
    step(0, 1, 2, 0, 0, 0, 0);
    step(1, 1, 2, 0, 0, 0, 0);

    // Shift 1,0,1,1 from 0000
    step(0, 1, 3, 0, 0, 0, 1);
    step(0, 1, 3, 0, 0, 0, 0);
    step(0, 1, 3, 0, 0, 0, 1);
    step(0, 1, 3, 0, 0, 0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
